// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the IFU/LSU memory arbiter.
//   arb_state_e : arbiter FSM states (idle, request on bus, waiting for response)
//   arb_owner_e : which master owns the in-flight transaction / was granted last
package mem_arbiter_pkg;

    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational 2-way round-robin picker.
//   ifu_valid, lsu_valid : pending requests
//   last_grant           : master granted most recently
//   grant_ifu, grant_lsu : one-hot grant (both 0 when nobody requests)
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  arb_owner_e last_grant,
    output logic       grant_ifu,
    output logic       grant_lsu
);

    // Lone requester wins; on a tie the master that was not granted last wins.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        case ({ifu_valid, lsu_valid})
            2'b10: grant_ifu = 1'b1;
            2'b01: grant_lsu = 1'b1;
            2'b11: begin
                if (last_grant == OWN_LSU) begin
                    grant_ifu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end
            default: begin
                grant_ifu = 1'b0;
                grant_lsu = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IFU fetches and LSU loads/stores onto one memory port.
// At most one transaction is outstanding; responses are routed to the issuing master.
//   clk, rst                : clock, asynchronous active-low reset
//   ifu_req_*/ifu_addr      : IFU request handshake and fetch address
//   ifu_resp_valid/ifu_rdata: IFU response pulse and data
//   lsu_req_*/lsu_*         : LSU request handshake, address, store controls/data
//   lsu_resp_valid/lsu_rdata: LSU response pulse (load data or store ack)
//   mem_req_*/mem_*         : latched request to memory, valid/ready handshake
//   mem_resp_valid/mem_rdata: memory response, one per accepted request
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_r;
    arb_owner_e        owner_r;
    arb_owner_e        last_grant_r;
    logic              mem_req_valid_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_wen_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [MASK_W-1:0] mem_wmask_r;
    logic              grant_ifu_s;
    logic              grant_lsu_s;

    arb_pick u_arb_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant_r),
        .grant_ifu  (grant_ifu_s),
        .grant_lsu  (grant_lsu_s)
    );

    assign mem_req_valid = mem_req_valid_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wen       = mem_wen_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_wmask     = mem_wmask_r;

    // Read data is shared; only the owner's resp_valid qualifies it.
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

    // Accept handshakes only in IDLE; forward a response only while waiting for one.
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        if (state_r == ST_IDLE) begin
            ifu_req_ready = grant_ifu_s;
            lsu_req_ready = grant_lsu_s;
        end else begin
            ifu_req_ready = 1'b0;
            lsu_req_ready = 1'b0;
        end
        if ((state_r == ST_WAIT) && mem_resp_valid) begin
            ifu_resp_valid = (owner_r == OWN_IFU);
            lsu_resp_valid = (owner_r == OWN_LSU);
        end else begin
            ifu_resp_valid = 1'b0;
            lsu_resp_valid = 1'b0;
        end
    end

    // Arbiter FSM with request latch; mem_req_valid is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            owner_r         <= OWN_IFU;
            last_grant_r    <= OWN_LSU;
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= {ADDR_W{1'b0}};
            mem_wen_r       <= 1'b0;
            mem_wdata_r     <= {DATA_W{1'b0}};
            mem_wmask_r     <= {MASK_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_ifu_s) begin
                        // Fetches are always reads with no byte enables.
                        owner_r         <= OWN_IFU;
                        last_grant_r    <= OWN_IFU;
                        mem_addr_r      <= ifu_addr;
                        mem_wen_r       <= 1'b0;
                        mem_wdata_r     <= {DATA_W{1'b0}};
                        mem_wmask_r     <= {MASK_W{1'b0}};
                        mem_req_valid_r <= 1'b1;
                        state_r         <= ST_REQ;
                    end else if (grant_lsu_s) begin
                        owner_r         <= OWN_LSU;
                        last_grant_r    <= OWN_LSU;
                        mem_addr_r      <= lsu_addr;
                        mem_wen_r       <= lsu_wen;
                        mem_wdata_r     <= lsu_wdata;
                        mem_wmask_r     <= lsu_wmask;
                        mem_req_valid_r <= 1'b1;
                        state_r         <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        state_r         <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    mem_req_valid_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A transaction-level model
// (busy / bus-accepted flags, last grant, latched fields) predicts every output
// each cycle; directed scenarios are followed by a randomized traffic phase.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one transaction in flight at most.
    bit          m_busy, m_acc, m_own_lsu, m_last_lsu;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [7:0]  m_wmask;
    int          exp_ifu_cnt = 0, exp_lsu_cnt = 0, obs_ifu_cnt = 0, obs_lsu_cnt = 0;

    // Outputs captured mid-cycle by the last tick.
    logic        o_ifu_rdy, o_lsu_rdy, o_ifu_resp, o_lsu_resp, o_mreq;
    logic [31:0] o_ifu_rdata, o_lsu_rdata, o_addr, o_wdata;
    logic        o_wen;
    logic [7:0]  o_wmask;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_acc = 1'b0; m_own_lsu = 1'b0; m_last_lsu = 1'b1;
        m_addr = 32'h0; m_wdata = 32'h0; m_wen = 1'b0; m_wmask = 8'h00;
    endtask

    task automatic zero_inputs();
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 8'h00;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    endtask

    // One clock cycle: check at negedge, advance model at posedge, return at posedge+1.
    task automatic tick();
        bit e_ifu_rdy, e_lsu_rdy, e_ifu_resp, e_lsu_resp, e_mreq;
        @(negedge clk);
        e_ifu_rdy = 1'b0;
        e_lsu_rdy = 1'b0;
        if (!m_busy) begin
            if (ifu_req_valid && lsu_req_valid) begin
                e_ifu_rdy = m_last_lsu;
                e_lsu_rdy = !m_last_lsu;
            end else begin
                e_ifu_rdy = ifu_req_valid;
                e_lsu_rdy = lsu_req_valid;
            end
        end
        e_mreq     = m_busy && !m_acc;
        e_ifu_resp = m_busy && m_acc && mem_resp_valid && !m_own_lsu;
        e_lsu_resp = m_busy && m_acc && mem_resp_valid && m_own_lsu;
        check_eq("ifu_req_ready",  32'(ifu_req_ready),  32'(e_ifu_rdy));
        check_eq("lsu_req_ready",  32'(lsu_req_ready),  32'(e_lsu_rdy));
        check_eq("mem_req_valid",  32'(mem_req_valid),  32'(e_mreq));
        check_eq("ifu_resp_valid", 32'(ifu_resp_valid), 32'(e_ifu_resp));
        check_eq("lsu_resp_valid", 32'(lsu_resp_valid), 32'(e_lsu_resp));
        check_eq("mem_addr",  mem_addr,  m_addr);
        check_eq("mem_wen",   32'(mem_wen),   32'(m_wen));
        check_eq("mem_wdata", mem_wdata, m_wdata);
        check_eq("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
        check_eq("ifu_rdata", ifu_rdata, mem_rdata);
        check_eq("lsu_rdata", lsu_rdata, mem_rdata);
        o_ifu_rdy = ifu_req_ready; o_lsu_rdy = lsu_req_ready;
        o_ifu_resp = ifu_resp_valid; o_lsu_resp = lsu_resp_valid; o_mreq = mem_req_valid;
        o_ifu_rdata = ifu_rdata; o_lsu_rdata = lsu_rdata;
        o_addr = mem_addr; o_wdata = mem_wdata; o_wen = mem_wen; o_wmask = mem_wmask;
        obs_ifu_cnt += int'(ifu_resp_valid); obs_lsu_cnt += int'(lsu_resp_valid);
        exp_ifu_cnt += int'(e_ifu_resp);     exp_lsu_cnt += int'(e_lsu_resp);
        @(posedge clk);
        if (rst) begin
            if (!m_busy) begin
                if (e_ifu_rdy) begin
                    m_busy = 1'b1; m_acc = 1'b0; m_own_lsu = 1'b0; m_last_lsu = 1'b0;
                    m_addr = ifu_addr; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 8'h00;
                end else if (e_lsu_rdy) begin
                    m_busy = 1'b1; m_acc = 1'b0; m_own_lsu = 1'b1; m_last_lsu = 1'b1;
                    m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                end
            end else if (!m_acc) begin
                if (mem_req_ready) m_acc = 1'b1;
            end else if (mem_resp_valid) begin
                m_busy = 1'b0;
                m_acc  = 1'b0;
            end
        end
        #1;
    endtask

    // Randomized masters and memory with random stalls, latencies and spurious responses.
    task automatic rand_phase(input int n);
        bit mem_out = 1'b0;
        int dly = 0;
        for (int c = 0; c < n; c++) begin
            if (!ifu_req_valid && ($urandom_range(0, 1) == 1)) begin
                ifu_req_valid = 1'b1;
                ifu_addr      = $urandom;
            end
            if (!lsu_req_valid && ($urandom_range(0, 1) == 1)) begin
                lsu_req_valid = 1'b1;
                lsu_addr      = $urandom;
                lsu_wen       = 1'($urandom_range(0, 1));
                lsu_wdata     = $urandom;
                lsu_wmask     = 8'($urandom_range(0, 255));
            end
            mem_req_ready = ($urandom_range(0, 2) != 0);
            mem_rdata     = $urandom;
            if (mem_out) mem_resp_valid = (dly == 0);
            else         mem_resp_valid = ($urandom_range(0, 7) == 0);
            tick();
            if (o_ifu_rdy) ifu_req_valid = 1'b0;
            if (o_lsu_rdy) lsu_req_valid = 1'b0;
            if (mem_out) begin
                if (mem_resp_valid) mem_out = 1'b0;
                else                dly--;
            end else if (o_mreq && mem_req_ready) begin
                mem_out = 1'b1;
                dly     = $urandom_range(0, 3);
            end
        end
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        zero_inputs();
        model_reset();
        tick();
        check_eq("rst_mem_req_valid", 32'(o_mreq), 32'h0);
        check_eq("rst_mem_addr", o_addr, 32'h0);
        rst = 1'b1;
        tick();

        // Lone IFU fetch, minimum latency.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        tick();
        check_eq("fetch_accept", 32'(o_ifu_rdy), 32'h1);
        ifu_req_valid = 1'b0;
        tick();
        check_eq("fetch_mem_addr", o_addr, 32'h8000_0000);
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        tick();
        check_eq("fetch_resp", 32'(o_ifu_resp), 32'h1);
        check_eq("fetch_rdata", o_ifu_rdata, 32'h0000_0413);
        check_eq("fetch_no_lsu_resp", 32'(o_lsu_resp), 32'h0);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        tick();

        // LSU store; fields stay stable in REQ while the LSU inputs change.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        tick();
        check_eq("store_accept", 32'(o_lsu_rdy), 32'h1);
        lsu_req_valid = 1'b0; lsu_addr = 32'h1234_5678; lsu_wdata = 32'h0; lsu_wmask = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("store_wen", 32'(o_wen), 32'h1);
            check_eq("store_wdata", o_wdata, 32'hDEAD_BEEF);
            check_eq("store_wmask", 32'(o_wmask), 32'h0F);
            check_eq("store_addr", o_addr, 32'h8000_1000);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        tick();
        check_eq("store_ack", 32'(o_lsu_resp), 32'h1);
        mem_resp_valid = 1'b0;

        // Back-to-back ties right after reset: grants alternate starting with IFU.
        rst = 1'b0; zero_inputs(); model_reset();
        tick();
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("tie_grant_ifu", 32'(o_ifu_rdy), 32'((i % 2) == 0));
            check_eq("tie_grant_lsu", 32'(o_lsu_rdy), 32'((i % 2) == 1));
            tick();
            mem_resp_valid = 1'b1;
            tick();
            mem_resp_valid = 1'b0;
        end

        // Stall: 5 cycles without mem_req_ready, response 3 cycles after bus accept.
        lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
        tick();
        pulses = int'(o_ifu_resp);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_mem_req_valid", 32'(o_mreq), 32'h1);
            check_eq("stall_ifu_ready", 32'(o_ifu_rdy), 32'h0);
            check_eq("stall_lsu_ready", 32'(o_lsu_rdy), 32'h0);
            check_eq("stall_addr", o_addr, 32'h8000_0040);
            pulses += int'(o_ifu_resp);
        end
        mem_req_ready = 1'b1;
        tick();
        pulses += int'(o_ifu_resp);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            pulses += int'(o_ifu_resp);
        end
        mem_resp_valid = 1'b1;
        tick();
        pulses += int'(o_ifu_resp);
        check_eq("stall_resp_pulses", 32'(pulses), 32'h1);
        mem_resp_valid = 1'b0;
        tick();
        check_eq("stall_lsu_next", 32'(o_lsu_rdy), 32'h1);
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;

        // Spurious responses in IDLE and REQ are dropped.
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        tick();
        check_eq("spur_idle_ifu", 32'(o_ifu_resp), 32'h0);
        check_eq("spur_idle_lsu", 32'(o_lsu_resp), 32'h0);
        mem_resp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        tick();
        check_eq("spur_still_idle", 32'(o_ifu_rdy), 32'h1);
        ifu_req_valid = 1'b0; mem_resp_valid = 1'b1;
        tick();
        check_eq("spur_req_ifu", 32'(o_ifu_resp), 32'h0);
        check_eq("spur_req_hold", 32'(o_mreq), 32'h1);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();

        // Asynchronous reset in WAIT aborts the transaction immediately.
        #3;
        rst = 1'b0; mem_resp_valid = 1'b1;
        #1;
        check_eq("arst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check_eq("arst_ifu_resp", 32'(ifu_resp_valid), 32'h0);
        check_eq("arst_lsu_resp", 32'(lsu_resp_valid), 32'h0);
        check_eq("arst_ifu_ready", 32'(ifu_req_ready), 32'h0);
        check_eq("arst_lsu_ready", 32'(lsu_req_ready), 32'h0);
        check_eq("arst_mem_addr", mem_addr, 32'h0);
        check_eq("arst_mem_wen", 32'(mem_wen), 32'h0);
        check_eq("arst_mem_wdata", mem_wdata, 32'h0);
        check_eq("arst_mem_wmask", 32'(mem_wmask), 32'h0);
        model_reset();
        tick();
        mem_resp_valid = 1'b0; rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200; mem_req_ready = 1'b1;
        tick();
        check_eq("post_rst_accept", 32'(o_ifu_rdy), 32'h1);
        ifu_req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h0051_0513;
        tick();
        check_eq("post_rst_resp", 32'(o_ifu_resp), 32'h1);
        check_eq("post_rst_rdata", o_ifu_rdata, 32'h0051_0513);
        mem_resp_valid = 1'b0;

        rand_phase(800);

        check_eq("ifu_resp_total", 32'(obs_ifu_cnt), 32'(exp_ifu_cnt));
        check_eq("lsu_resp_total", 32'(obs_lsu_cnt), 32'(exp_lsu_cnt));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
